// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
//
// Handshake: a request is transferred on a rising edge where imem_req_o and
// imem_gnt_i are both high; imem_addr_o is only meaningful while imem_req_o
// is high. The response is the single later cycle with imem_rvalid_i high,
// with imem_rdata_i valid in that same cycle. Only one request may be
// outstanding, so responses carry no tag.
interface fetch_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with integrated IF/ID register. Holds the PC,
// keeps at most one fetch in flight, parks a returned word in a skid
// register while the decode side is stalled, and redirects on taken
// branches. Responses to fetches overtaken by a redirect are discarded.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               reset_n,
   fetch_stage_if.master      imem,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               branch_taken_i,
   input  logic [31:0]        branch_target_i,
   output logic [31:0]        IF_ID_instruction_o,
   output logic [31:0]        IF_ID_pc_o,
   output logic               IF_ID_valid_o,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      BOOT = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] skid_q;

   logic [31:0] target_pc;
   logic [31:0] pc_inc;
   logic [31:0] load_word;
   logic        load_now;
   logic        unused_target_lsbs;

   // Redirect targets are word aligned; the low two bits are dropped.
   assign target_pc          = {branch_target_i[31:2], 2'b00};
   assign unused_target_lsbs = &{1'b0, branch_target_i[1:0]};
   assign pc_inc             = pc_q + 32'd4;

   // A word enters IF/ID when a live response arrives or the skid drains,
   // provided decode is not stalled and no redirect is in progress.
   assign load_now  = !branch_taken_i && !stall_i &&
                      (((state == WAIT) && imem.imem_rvalid_i) || (state == HOLD));
   assign load_word = (state == HOLD) ? skid_q : imem.imem_rdata_i;

   assign imem.imem_req_o  = (state == REQ);
   assign imem.imem_addr_o = pc_q;
   assign dbg_state        = state;

   // Fetch FSM: PC, outstanding-request tracking and skid buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= BOOT;
         pc_q   <= RESET_PC;
         skid_q <= '0;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
               if (branch_taken_i) pc_q <= target_pc;
            end
            REQ: begin
               if (branch_taken_i) begin
                  // An ungranted address may simply change; a granted one
                  // leaves a response that must be thrown away.
                  pc_q <= target_pc;
                  if (imem.imem_gnt_i) state <= DROP;
               end else if (imem.imem_gnt_i) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (branch_taken_i) begin
                  pc_q  <= target_pc;
                  state <= imem.imem_rvalid_i ? REQ : DROP;
               end else if (imem.imem_rvalid_i) begin
                  if (stall_i) begin
                     skid_q <= imem.imem_rdata_i;
                     state  <= HOLD;
                  end else begin
                     pc_q  <= pc_inc;
                     state <= REQ;
                  end
               end
            end
            HOLD: begin
               if (branch_taken_i) begin
                  pc_q  <= target_pc;
                  state <= REQ;
               end else if (!stall_i) begin
                  pc_q  <= pc_inc;
                  state <= REQ;
               end
            end
            DROP: begin
               if (branch_taken_i) pc_q <= target_pc;
               if (imem.imem_rvalid_i) state <= REQ;
            end
            default: state <= BOOT;
         endcase
      end
   end

   // IF/ID register: flush/redirect bubble, then stall hold, then new word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         IF_ID_instruction_o <= NOP_INSTR;
         IF_ID_pc_o          <= '0;
         IF_ID_valid_o       <= 1'b0;
      end else if (flush_i || branch_taken_i) begin
         IF_ID_instruction_o <= NOP_INSTR;
         IF_ID_pc_o          <= '0;
         IF_ID_valid_o       <= 1'b0;
      end else if (stall_i) begin
         IF_ID_instruction_o <= IF_ID_instruction_o;
         IF_ID_pc_o          <= IF_ID_pc_o;
         IF_ID_valid_o       <= IF_ID_valid_o;
      end else if (load_now) begin
         IF_ID_instruction_o <= load_word;
         IF_ID_pc_o          <= pc_q;
         IF_ID_valid_o       <= 1'b1;
      end else begin
         IF_ID_instruction_o <= NOP_INSTR;
         IF_ID_pc_o          <= '0;
         IF_ID_valid_o       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed reset / wrap / async-reset checks, then
// randomized memory timing, stalls, flushes and redirects against a
// transaction-level model of which words must reach IF/ID.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic        stall, flush, br;
   logic [31:0] tgt;
   logic [31:0] id_instr, id_pc;
   logic        id_valid;
   logic [2:0]  dbg;
   fetch_stage_if mif ();

   fetch_stage u_dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .imem                (mif),
      .stall_i             (stall),
      .flush_i             (flush),
      .branch_taken_i      (br),
      .branch_target_i     (tgt),
      .IF_ID_instruction_o (id_instr),
      .IF_ID_pc_o          (id_pc),
      .IF_ID_valid_o       (id_valid),
      .dbg_state           (dbg)
   );

   // ---------------- wrap-around DUT (RESET_PC at top of memory) ----------------
   logic [31:0] w_instr, w_pc;
   logic        w_valid;
   logic [2:0]  w_dbg;
   fetch_stage_if wif ();

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk                 (clk),
      .reset_n             (reset_n),
      .imem                (wif),
      .stall_i             (1'b0),
      .flush_i             (1'b0),
      .branch_taken_i      (1'b0),
      .branch_target_i     (32'h0),
      .IF_ID_instruction_o (w_instr),
      .IF_ID_pc_o          (w_pc),
      .IF_ID_valid_o       (w_valid),
      .dbg_state           (w_dbg)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];   // {instruction, pc} expected in IF/ID, in order

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // ---------------- reference model / memory state ----------------
   logic [31:0] exp_pc;      // address the next live fetch must use
   bit          m_stale;     // in-flight response belongs to an abandoned path
   bit          m_held;      // a fetched word is waiting for the stall to lift
   bit          mem_busy;    // memory owes one response
   int          mem_lat;
   logic [31:0] mem_addr;
   bit          p_br, p_fl, p_st;
   logic [31:0] last_instr, last_pc;
   logic        last_valid;
   bit          mon_en = 1'b0;

   // Drive one cycle of stimulus and advance the model across the coming edge.
   task automatic step(input bit zero_wait, input int pst, input int pfl, input int pbr);
      logic        rv, gn, spur, load;
      logic [31:0] lpc;
      stall = ($urandom_range(0, 99) < pst);
      flush = ($urandom_range(0, 99) < pfl);
      br    = ($urandom_range(0, 99) < pbr);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           tgt = 32'($urandom_range(0, 511));

      rv   = mem_busy && (mem_lat == 0);
      spur = !zero_wait && !mem_busy && ($urandom_range(0, 9) == 0);
      mif.imem_rvalid_i = rv || spur;
      mif.imem_rdata_i  = rv ? mem_word(mem_addr) : $urandom;
      gn = mif.imem_req_o && !mem_busy && (zero_wait || ($urandom_range(0, 99) < 70));
      mif.imem_gnt_i = gn;

      if (mif.imem_req_o) check("single_outstanding", 96'(mem_busy), 96'd0);
      if (gn) check("req_addr", 96'(mif.imem_addr_o), 96'(exp_pc));

      load = 1'b0;
      lpc  = '0;
      if (br) begin
         if (mem_busy && !rv) m_stale = 1'b1;
         m_held = 1'b0;
         exp_pc = {tgt[31:2], 2'b00};
      end else if (rv && !m_stale) begin
         if (stall) m_held = 1'b1;
         else begin
            load = 1'b1; lpc = exp_pc; exp_pc = exp_pc + 32'd4;
         end
      end else if (m_held && !stall) begin
         load = 1'b1; lpc = exp_pc; exp_pc = exp_pc + 32'd4; m_held = 1'b0;
      end
      if (rv) m_stale = 1'b0;
      if (gn) m_stale = br;
      if (load && !flush) exp_q.push_back({mem_word(lpc), lpc});

      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_lat--;
      if (gn) begin
         mem_busy = 1'b1;
         mem_addr = mif.imem_addr_o;
         mem_lat  = zero_wait ? 0 : $urandom_range(0, 2);
      end
      p_br = br; p_fl = flush; p_st = stall;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (p_fl || p_br) begin
            check("ifid_bubble_flush", {31'd0, id_valid, id_pc, id_instr}, {31'd0, 1'b0, 32'd0, NOP});
         end else if (p_st) begin
            check("ifid_hold", {31'd0, id_valid, id_pc, id_instr},
                  {31'd0, last_valid, last_pc, last_instr});
         end else if (id_valid) begin
            if (exp_q.size() == 0) check("unexpected_load", 96'(exp_q.size() != 0), 96'd1);
            else check("ifid_load", {32'd0, id_instr, id_pc}, {32'd0, exp_q.pop_front()});
         end else begin
            check("ifid_bubble", {31'd0, id_valid, id_pc, id_instr}, {31'd0, 1'b0, 32'd0, NOP});
            check("missing_load", 96'(exp_q.size()), 96'd0);
         end
         last_instr = id_instr;
         last_pc    = id_pc;
         last_valid = id_valid;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      stall = 1'b0; flush = 1'b0; br = 1'b0; tgt = '0;
      mif.imem_gnt_i = 1'b0; mif.imem_rvalid_i = 1'b0; mif.imem_rdata_i = '0;
      wif.imem_gnt_i = 1'b0; wif.imem_rvalid_i = 1'b0; wif.imem_rdata_i = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", 96'(mif.imem_req_o), 96'd0);
      check("rst_ifid", {31'd0, id_valid, id_pc, id_instr}, {31'd0, 1'b0, 32'd0, NOP});
      check("rst_wrap_req", 96'(wif.imem_req_o), 96'd0);
      #1 reset_n = 1'b1;
      #1 check("boot_no_req", 96'(mif.imem_req_o), 96'd0);

      // First request one cycle after release
      @(negedge clk);
      check("first_req", {63'd0, mif.imem_req_o, mif.imem_addr_o}, {63'd0, 1'b1, 32'h0});
      check("wrap_first_req", {63'd0, wif.imem_req_o, wif.imem_addr_o}, {63'd0, 1'b1, 32'hFFFF_FFFC});

      // Wrap DUT: one zero-wait fetch at 0xFFFFFFFC, next address wraps to 0
      #1 wif.imem_gnt_i = 1'b1;
      @(negedge clk);
      #1 wif.imem_gnt_i = 1'b0; wif.imem_rvalid_i = 1'b1; wif.imem_rdata_i = 32'h0010_0093;
      @(negedge clk);
      check("wrap_ifid", {31'd0, w_valid, w_pc, w_instr}, {31'd0, 1'b1, 32'hFFFF_FFFC, 32'h0010_0093});
      check("wrap_next_addr", {63'd0, wif.imem_req_o, wif.imem_addr_o}, {63'd0, 1'b1, 32'h0});
      #1 wif.imem_rvalid_i = 1'b0;

      // Main DUT: grant, then assert reset asynchronously while waiting
      mif.imem_gnt_i = 1'b1;
      @(negedge clk);
      #1 mif.imem_gnt_i = 1'b0;
      check("wait_no_req", 96'(mif.imem_req_o), 96'd0);
      #2 reset_n = 1'b0;
      #1 check("async_rst_ifid", {31'd0, id_valid, id_pc, id_instr}, {31'd0, 1'b0, 32'd0, NOP});
      check("async_rst_addr", 96'(mif.imem_addr_o), 96'd0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      mif.imem_rvalid_i = 1'b1; mif.imem_rdata_i = 32'hDEAD_BEEF;   // late response
      @(negedge clk);
      check("late_rvalid_ignored", {63'd0, id_valid, mif.imem_req_o, mif.imem_addr_o},
            {63'd0, 1'b0, 1'b1, 32'h0});
      #1 mif.imem_rvalid_i = 1'b0;

      // Randomized phase with the model; starts in REQ at address 0
      exp_pc = 32'h0; m_stale = 1'b0; m_held = 1'b0;
      mem_busy = 1'b0; mem_lat = 0; mem_addr = '0;
      p_br = 1'b0; p_fl = 1'b0; p_st = 1'b0;
      last_instr = NOP; last_pc = '0; last_valid = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 0, 0, 0);
         @(negedge clk);
         #1;
      end
      for (int i = 0; i < 4000; i++) begin
         step(1'b0, 30, 8, 6);
         @(negedge clk);
         #1;
      end
      mon_en = 1'b0;
      check("exp_q_drained", 96'(exp_q.size()), 96'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
